// File: rtl/dmem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cpu19_pkg
// Shared definitions for the 19-bit CPU data-memory path: bus widths and the
// state type of the data-memory port arbiter.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu19_pkg;

    localparam int unsigned DATA_W = 19;
    localparam int unsigned ADDR_W = 19;

    // S_RUN   : CPU has priority, debug takes idle cycles
    // S_FORCE : one cycle where a starved debug request goes first
    // S_HALT  : debug port owns the memory exclusively
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FORCE = 2'd1,
        S_HALT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the CPU MEM-stage request, the debug/loader request and the data
// memory array connection of the data-memory port arbiter.
// Modports:
//   slave  : the arbiter (consumes requests and mem_rdata, drives grants,
//            read data and the memory request)
//   master : the surrounding system (pipeline, debug port, memory array)
// ----------------------------------------------------------------------------
interface dmem_port_arbiter_if;
    import cpu19_pkg::*;

    // CPU MEM stage
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Debug / loader port
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_halt;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              halted;

    // Data memory array
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dbg_gnt, dbg_rvalid, dbg_rdata, halted,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, halted,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_port_arbiter_wait_counter.sv
// ----------------------------------------------------------------------------
// arb_wait_counter
// Counts consecutive cycles in which a debug request was pending but lost
// arbitration. Saturates at DBG_WAIT_MAX; clears on a debug grant or when the
// request is withdrawn.
// Ports:
//   clk         in  clock, rising edge
//   rst         in  asynchronous reset, active-low
//   i_dbg_req   in  debug request pending
//   i_dbg_gnt   in  debug request granted this cycle
//   o_at_limit  out wait count equals DBG_WAIT_MAX-1 (this lost cycle is the
//                   last one allowed before a forced debug slot)
// ----------------------------------------------------------------------------
module arb_wait_counter #(
    parameter int unsigned DBG_WAIT_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dbg_req,
    input  logic i_dbg_gnt,
    output logic o_at_limit
);

    localparam logic [3:0] LP_MAX = 4'(DBG_WAIT_MAX);

    logic [3:0] r_wait_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 4'd0;
        end else if (!i_dbg_req || i_dbg_gnt) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != LP_MAX) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign o_at_limit = (r_wait_cnt == LP_MAX - 4'd1);

endmodule

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port data memory between the CPU MEM stage and a
// debug/loader port. The CPU has priority; after DBG_WAIT_MAX consecutive lost
// cycles the debug port gets one forced slot. dbg_halt locks the memory to the
// debug port. cpu_stall freezes the MEM stage whenever its request is not
// granted.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous reset, active-low
//   bus  slave modport of dmem_port_arbiter_if:
//        cpu_req/we/addr/wdata in, cpu_rdata/cpu_stall out (combinational)
//        dbg_req/we/addr/wdata/halt in, dbg_gnt out (combinational),
//        dbg_rvalid/dbg_rdata out (registered), halted out
//        mem_we/addr/wdata out (combinational), mem_rdata in
// ----------------------------------------------------------------------------
module dmem_port_arbiter
    import cpu19_pkg::*;
#(
    parameter int unsigned DBG_WAIT_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic              w_at_limit;
    logic              w_dbg_rd;
    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_dbg_rdata;

    arb_wait_counter #(
        .DBG_WAIT_MAX (DBG_WAIT_MAX)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_dbg_req  (bus.dbg_req),
        .i_dbg_gnt  (w_dbg_gnt),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_cpu_gnt   = 1'b0;
        w_dbg_gnt   = 1'b0;
        w_state_nxt = r_state;

        case (r_state)
            S_FORCE: begin
                w_dbg_gnt = bus.dbg_req;
                // A withdrawn debug request gives the forced slot back to the CPU.
                w_cpu_gnt = bus.cpu_req & ~bus.dbg_req;
            end
            S_HALT: begin
                w_dbg_gnt = bus.dbg_req;
            end
            default: begin
                // S_RUN, and the unused encoding recovers as S_RUN.
                w_cpu_gnt = bus.cpu_req;
                w_dbg_gnt = bus.dbg_req & ~bus.cpu_req;
            end
        endcase

        // Halt has priority over everything, including a pending force.
        if (bus.dbg_halt) begin
            w_state_nxt = S_HALT;
        end else if (r_state == S_HALT || r_state == S_FORCE) begin
            w_state_nxt = S_RUN;
        end else if (bus.dbg_req && bus.cpu_req && w_at_limit) begin
            w_state_nxt = S_FORCE;
        end
    end

    // Debug read data is captured from the memory in the grant cycle and
    // presented one cycle later; it holds until the next granted read.
    assign w_dbg_rd = w_dbg_gnt & ~bus.dbg_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_dbg_rvalid <= w_dbg_rd;
            if (w_dbg_rd) begin
                r_dbg_rdata <= bus.mem_rdata;
            end
        end
    end

    // Memory mux: the debug port drives the memory only when granted; the CPU
    // address/data are presented otherwise, with the write gated by its grant.
    assign bus.mem_we    = w_dbg_gnt ? bus.dbg_we    : (w_cpu_gnt & bus.cpu_we);
    assign bus.mem_addr  = w_dbg_gnt ? bus.dbg_addr  : bus.cpu_addr;
    assign bus.mem_wdata = w_dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;

    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_gnt;
    assign bus.dbg_gnt    = w_dbg_gnt;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.dbg_rdata  = r_dbg_rdata;
    assign bus.halted     = (r_state == S_HALT);

endmodule
